// File: rtl/icache_line_fill_if.sv
// Signal bundle between the refill engine, the instruction cache and the narrow memory bus.
// The slave view belongs to the refill engine. The master view belongs to the environment (cache plus memory).
interface icache_line_fill_if #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int BUS_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 32
);
  logic                         fill_req;
  logic [ADDR_WIDTH-1:0]        fill_addr;
  logic [LINE_SIZE_BYTES*8-1:0] fill_data;
  logic                         fill_valid;
  logic                         busy;
  logic                         bus_req;
  logic [ADDR_WIDTH-1:0]        bus_addr;
  logic                         bus_ready;
  logic [BUS_WIDTH-1:0]         bus_rdata;
  logic                         bus_rvalid;

  modport slave (
    input  fill_req, fill_addr, bus_ready, bus_rdata, bus_rvalid,
    output fill_data, fill_valid, busy, bus_req, bus_addr
  );

  modport master (
    output fill_req, fill_addr, bus_ready, bus_rdata, bus_rvalid,
    input  fill_data, fill_valid, busy, bus_req, bus_addr
  );
endinterface

// File: rtl/icache_line_fill.sv
// Cache-line refill engine: issues one single-beat read per bus word and assembles the line.
// It then signals completion with a one-cycle fill_valid pulse.
module icache_line_fill #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int BUS_WIDTH       = 32,
  parameter int ADDR_WIDTH      = 32
) (
  input logic                clk,
  input logic                rst_n,
  icache_line_fill_if.slave  fill
);
  localparam int BEATS      = LINE_SIZE_BYTES * 8 / BUS_WIDTH;
  localparam int BEAT_BYTES = BUS_WIDTH / 8;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_SIZE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_STEP = ADDR_WIDTH'(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                              state_q;
  logic [BEAT_W-1:0]                   beat_q;
  logic [ADDR_WIDTH-1:0]               bus_addr_q;
  logic [BEATS-1:0][BUS_WIDTH-1:0]     line_q;
  logic                                bus_req_q;
  logic                                busy_q;
  logic                                fill_valid_q;

  // Outputs are registered alongside the state, so no input reaches an output combinationally.
  // bus_addr_q walks base + beat*BEAT_BYTES and wraps modulo 2^ADDR_WIDTH.
  // NOTE: every state register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      bus_addr_q   <= '0;
      // NOTE: the line buffer is datapath but is still reset so fill_data reads zero after reset.
      line_q       <= '0;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fill.fill_req) begin
            bus_addr_q <= fill.fill_addr & LINE_MASK;
            beat_q     <= '0;
            bus_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (fill.bus_ready) begin
            bus_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (fill.bus_rvalid) begin
            line_q[beat_q] <= fill.bus_rdata;
            if (beat_q == LAST_BEAT) begin
              fill_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              beat_q     <= beat_q + 1'b1;
              bus_addr_q <= bus_addr_q + BEAT_STEP;
              bus_req_q  <= 1'b1;
              state_q    <= REQ;
            end
          end
        end
        DONE: begin
          fill_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fill.fill_data  = line_q;
  assign fill.fill_valid = fill_valid_q;
  assign fill.busy       = busy_q;
  assign fill.bus_req    = bus_req_q;
  assign fill.bus_addr   = bus_addr_q;
endmodule
